oven_timer_ctrl: RTL and testbench
==================================

Name: oven_timer_ctrl

Overview:
- Sequencing controller for the microwave countdown timer datapath: loads the preset time, generates the per-second decrement tick, gates heating, and handles pause, resume and cancel.
- Handles door-interlock, start, stop and load requests with a fixed priority.
- Signals completion with a timed beep.
- Sits between the front-panel inputs and the timer/heater; single clock domain.

Parameters:
- TW, 4, width of the time value (seconds).
- TICK_DIV, 4, clk cycles per one-second decrement tick (≥2).
- BEEP_LEN, 2, beep duration in ticks (BEEP_LEN*TICK_DIV cycles).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- tin  in  TW  preset time from the panel.
- load  in  1  capture tin into remain (level, sampled each clk).
- start  in  1  start/resume request.
- stop  in  1  cancel request; clears the time.
- door  in  1  1 = door open (interlock).
- remain  out  TW  registered remaining time.
- heat  out  1  heater enable, = (state==RUN), registered decode.
- beep  out  1  completion beep, = (state==DONE).
- state  out  3  current state code.

Behaviour:
- Reset (rst=0, async): state=IDLE, remain=0, prescaler=0, beep counter=0.
  - Outputs: heat=0, beep=0.
  - Reset released mid-RUN: returns to IDLE with the time lost.
- Input priority each cycle: stop > door > start > load.
- IDLE:
  - load → remain<=tin, then READY if tin!=0, else stay IDLE with remain=0.
  - start is ignored.
- READY:
  - stop → IDLE, remain<=0.
  - start & !door → RUN, prescaler<=0.
  - start & door → stay READY (ignored).
  - load → remain<=tin; tin==0 → IDLE.
- RUN:
  - heat=1 from the cycle after start was sampled (1-cycle latency).
  - Prescaler increments 0..TICK_DIV-1 and wraps; tick = (prescaler==TICK_DIV-1).
  - On tick: remain<=remain-1; if remain==1 → DONE with remain=0.
  - stop → IDLE, remain<=0, no decrement that cycle.
  - door=1 → PAUSE, prescaler held, no decrement even if tick coincides.
  - load ignored.
- PAUSE:
  - heat=0, remain and prescaler frozen.
  - start & !door → RUN, prescaler resumes from its held value.
  - stop → IDLE, remain<=0.
  - load ignored.
- DONE:
  - beep=1; beep counter counts BEEP_LEN*TICK_DIV cycles, then IDLE.
  - stop → IDLE immediately, beep drops the next cycle.
  - start and load ignored.
- Arithmetic: remain is unsigned TW bits and never decrements below 0; the DONE transition pre-empts wrap.
- The prescaler counter width is clog2(TICK_DIV); the beep counter is sized for BEEP_LEN*TICK_DIV.
- No combinational path from inputs to outputs; all outputs derive from registers.

Decomposition:
- Shared include file holds the state codes: IDLE=3'd0, READY=3'd1, RUN=3'd2, PAUSE=3'd3, DONE=3'd4. Unused codes 5–7 recover to IDLE.
- One sub-module: tick_gen.
  - Parameterised mod-TICK_DIV counter with enable (count), clear and tick output.
  - Instantiated for the prescaler.
- The FSM, remain register and beep counter stay in oven_timer_ctrl.

Test Plan:
1. Basic countdown:
   - Stimulus: reset, tin=3, pulse load, then start with door=0.
   - Response: state READY→RUN, heat=1 the cycle after start; remain 3→2→1→0 at 4-cycle intervals.
   - Then DONE with beep=1 for 8 cycles, then IDLE with heat=0.
2. Door interlock:
   - Stimulus: in RUN with remain=2, raise door on the same cycle as a tick.
   - Response: PAUSE, remain stays 2, heat=0.
   - Then: start with door=1 is ignored; door=0 plus start resumes RUN, and the next decrement occurs after the remaining prescaler count.
3. Cancel priority:
   - Stimulus: in RUN, assert stop, door and start together.
   - Response: IDLE, remain=0, heat=0 next cycle. Same result from PAUSE and from DONE (beep drops).
4. Zero / reload:
   - Stimulus: load with tin=0 in IDLE → stays IDLE, remain=0.
   - Stimulus: in READY with remain=5, load tin=9 → remain=9; load tin=0 → IDLE.
   - Stimulus: load during RUN → remain unaffected.
5. Async reset:
   - Stimulus: assert rst=0 mid-RUN between clock edges.
   - Response: immediately state=IDLE, remain=0, heat=0, beep=0; after release, start is ignored until a load.
6. Max value:
   - Stimulus: tin=15.
   - Response: 15 decrements over 60 cycles, no wrap to 15 after 0, DONE entered exactly once.

Source files
------------

// File: rtl/oven_timer_ctrl_pkg.sv
// Shared state encoding for the oven countdown sequencer.
package oven_timer_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READY = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/oven_timer_ctrl_tick_gen.sv
// Mod-DIV counter with enable and synchronous clear; tick marks the last count.
module tick_gen #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/oven_timer_ctrl.sv
// Microwave timer sequencer: preset load, per-second countdown, heat gating,
// pause/resume on door, cancel, and a timed completion beep.
module oven_timer_ctrl
    import oven_timer_ctrl_pkg::*;
#(
    parameter int unsigned TW       = 4,
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned BEEP_LEN = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [TW-1:0] tin,
    input  logic          load,
    input  logic          start,
    input  logic          stop,
    input  logic          door,
    output logic [TW-1:0] remain,
    output logic          heat,
    output logic          beep,
    output logic [2:0]    state
);

    localparam int unsigned BEEP_CYC = BEEP_LEN * TICK_DIV;
    localparam int unsigned BW       = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;

    state_t        cur, nxt;
    logic [TW-1:0] remain_q, remain_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          tick, pre_clear, pre_count;

    // Prescaler only advances in an uninterrupted RUN cycle, so a door
    // opening on a tick cycle freezes it at the terminal count.
    tick_gen #(
        .DIV(TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clear(pre_clear),
        .count(pre_count),
        .tick (tick)
    );

    always_comb begin
        nxt       = cur;
        remain_d  = remain_q;
        bcnt_d    = bcnt_q;
        pre_clear = 1'b0;
        pre_count = 1'b0;
        case (cur)
            IDLE: begin
                if (stop) begin
                    remain_d = '0;
                end else if (load && !start) begin
                    remain_d = tin;
                    if (tin != '0) nxt = READY;
                end
            end
            READY: begin
                if (stop) begin
                    nxt      = IDLE;
                    remain_d = '0;
                end else if (start && !door) begin
                    nxt       = RUN;
                    pre_clear = 1'b1;
                end else if (load && !start) begin
                    remain_d = tin;
                    if (tin == '0) nxt = IDLE;
                end
            end
            RUN: begin
                if (stop) begin
                    nxt      = IDLE;
                    remain_d = '0;
                end else if (door) begin
                    nxt = PAUSE;
                end else begin
                    pre_count = 1'b1;
                    if (tick) begin
                        // Last second goes straight to DONE so remain never wraps.
                        if (remain_q <= TW'(1)) begin
                            nxt      = DONE;
                            remain_d = '0;
                            bcnt_d   = '0;
                        end else begin
                            remain_d = remain_q - TW'(1);
                        end
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    nxt      = IDLE;
                    remain_d = '0;
                end else if (start && !door) begin
                    nxt = RUN;
                end
            end
            DONE: begin
                if (stop) begin
                    nxt = IDLE;
                end else if (bcnt_q == BW'(BEEP_CYC - 1)) begin
                    nxt = IDLE;
                end else begin
                    bcnt_d = bcnt_q + BW'(1);
                end
            end
            default: begin
                nxt      = IDLE;
                remain_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= IDLE;
            remain_q <= '0;
            bcnt_q   <= '0;
            heat     <= 1'b0;
            beep     <= 1'b0;
        end else begin
            cur      <= nxt;
            remain_q <= remain_d;
            bcnt_q   <= bcnt_d;
            heat     <= (nxt == RUN);
            beep     <= (nxt == DONE);
        end
    end

    assign remain = remain_q;
    assign state  = cur;

endmodule

// File: tb/tb_oven_timer_ctrl.sv
// Directed bench for oven_timer_ctrl with hand-computed expectations.
module tb_oven_timer_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_READY = 1;
    localparam int S_RUN   = 2;
    localparam int S_PAUSE = 3;
    localparam int S_DONE  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] tin = '0;
    logic       load = 1'b0, start = 1'b0, stop = 1'b0, door = 1'b0;
    logic [3:0] remain;
    logic       heat, beep;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    oven_timer_ctrl #(
        .TW      (4),
        .TICK_DIV(4),
        .BEEP_LEN(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tin   (tin),
        .load  (load),
        .start (start),
        .stop  (stop),
        .door  (door),
        .remain(remain),
        .heat  (heat),
        .beep  (beep),
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_all(input string tag, input int st, input int rem, input int ht, input int bp);
        check({tag, ".state"}, int'(state), st);
        check({tag, ".remain"}, int'(remain), rem);
        check({tag, ".heat"}, int'(heat), ht);
        check({tag, ".beep"}, int'(beep), bp);
    endtask

    task automatic do_load(input int v);
        tin  = 4'(v);
        load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    int done_entries;
    int prev_state;

    initial begin
        // Reset
        step(2);
        expect_all("reset", S_IDLE, 0, 0, 0);
        rst = 1'b1;
        step(1);

        // 1. Basic countdown
        do_start();
        check("idle_start_ignored", int'(state), S_IDLE);
        do_load(3);
        expect_all("t1_ready", S_READY, 3, 0, 0);
        do_start();
        expect_all("t1_run", S_RUN, 3, 1, 0);
        step(3);
        check("t1_pre_tick", int'(remain), 3);
        step(1);
        check("t1_rem2", int'(remain), 2);
        step(4);
        check("t1_rem1", int'(remain), 1);
        step(4);
        expect_all("t1_done", S_DONE, 0, 0, 1);
        step(7);
        expect_all("t1_beep_last", S_DONE, 0, 0, 1);
        step(1);
        expect_all("t1_idle", S_IDLE, 0, 0, 0);

        // 2. Door interlock on a tick cycle
        do_load(3);
        do_start();
        step(4);
        check("t2_rem2", int'(remain), 2);
        step(3);
        door = 1'b1;
        step(1);
        expect_all("t2_pause", S_PAUSE, 2, 0, 0);
        start = 1'b1;
        step(2);
        expect_all("t2_door_start", S_PAUSE, 2, 0, 0);
        door = 1'b0;
        step(1);
        start = 1'b0;
        expect_all("t2_resume", S_RUN, 2, 1, 0);
        step(1);
        check("t2_first_dec", int'(remain), 1);

        // 3. Cancel priority from RUN, PAUSE, DONE
        stop = 1'b1; door = 1'b1; start = 1'b1;
        step(1);
        stop = 1'b0; door = 1'b0; start = 1'b0;
        expect_all("t3_run_cancel", S_IDLE, 0, 0, 0);
        do_load(5);
        do_start();
        door = 1'b1;
        step(1);
        check("t3_pause", int'(state), S_PAUSE);
        stop = 1'b1; start = 1'b1;
        step(1);
        stop = 1'b0; door = 1'b0; start = 1'b0;
        expect_all("t3_pause_cancel", S_IDLE, 0, 0, 0);
        do_load(1);
        do_start();
        step(4);
        expect_all("t3_done", S_DONE, 0, 0, 1);
        stop = 1'b1; door = 1'b1; start = 1'b1;
        step(1);
        stop = 1'b0; door = 1'b0; start = 1'b0;
        expect_all("t3_done_cancel", S_IDLE, 0, 0, 0);

        // 4. Zero load and reload
        do_load(0);
        expect_all("t4_zero", S_IDLE, 0, 0, 0);
        do_load(5);
        expect_all("t4_load5", S_READY, 5, 0, 0);
        do_load(9);
        expect_all("t4_load9", S_READY, 9, 0, 0);
        do_load(0);
        expect_all("t4_load0", S_IDLE, 0, 0, 0);
        do_load(4);
        do_start();
        tin  = 4'd9;
        load = 1'b1;
        step(2);
        load = 1'b0;
        check("t4_run_load", int'(remain), 4);
        step(2);
        check("t4_run_dec", int'(remain), 3);

        // 5. Async reset mid-RUN, between edges
        check("t5_pre", int'(state), S_RUN);
        #2 rst = 1'b0;
        #1;
        expect_all("t5_async", S_IDLE, 0, 0, 0);
        #2 rst = 1'b1;
        step(1);
        start = 1'b1;
        step(2);
        start = 1'b0;
        expect_all("t5_start_ign", S_IDLE, 0, 0, 0);

        // 6. Max value
        do_load(15);
        check("t6_ready", int'(remain), 15);
        do_start();
        done_entries = 0;
        prev_state   = int'(state);
        for (int i = 1; i <= 68; i++) begin
            step(1);
            if (int'(state) == S_DONE && prev_state != S_DONE) done_entries++;
            prev_state = int'(state);
            if (i <= 60 && (i % 4) == 0)
                check($sformatf("t6_rem_%0d", i), int'(remain), 15 - i / 4);
        end
        check("t6_done_once", done_entries, 1);
        expect_all("t6_end", S_IDLE, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
